// File: rtl/icache_fill_pkg.sv
// Shared definitions for the instruction-cache fill path.
//   XLEN            : fetch/bus address width
//   ICACHE_LINES    : default number of direct-mapped lines
//   ICACHE_IDX_BITS : index width for the default line count
//   BUS_COMMAND     : memory bus command (shared with the arbiter)
//   ICACHE_LINE     : one cache line {valid, line tag, 64-bit data}
//   ICACHE_STATE    : miss-fill FSM states
package icache_fill_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned ICACHE_LINES    = 32;
   localparam int unsigned ICACHE_IDX_BITS = $clog2(ICACHE_LINES);
   // Widest possible line tag (a single-line cache). Narrower tags are zero-extended,
   // so the constant upper bits are pruned in synthesis.
   localparam int unsigned ICACHE_TAG_MAX  = XLEN - 3;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef struct packed {
      logic                      valid;
      logic [ICACHE_TAG_MAX-1:0] tag;
      logic [63:0]               data;
   } ICACHE_LINE;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ICACHE_STATE;

   // 8-byte-aligned block address of a byte address.
   function automatic logic [XLEN-1:0] block_addr(input logic [XLEN-1:0] a);
      return a & ~(XLEN'(7));
   endfunction

endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line storage for the instruction cache.
//   clock, reset : clock and asynchronous active-low reset (clears valid bits only)
//   rd_idx       : asynchronous read index
//   rd_line      : line at rd_idx
//   wr_en        : write the line at wr_idx on the rising edge
//   wr_idx       : write index
//   wr_line      : line contents to write
module icache_mem
   import icache_fill_pkg::*;
#(
   parameter int unsigned NUM_LINES = ICACHE_LINES,
   localparam int unsigned IDX_BITS = $clog2(NUM_LINES)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] rd_idx,
   output ICACHE_LINE          rd_line,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  ICACHE_LINE          wr_line
);

   logic [NUM_LINES-1:0]      valid_q;
   logic [ICACHE_TAG_MAX-1:0] tag_q  [NUM_LINES];
   logic [63:0]               data_q [NUM_LINES];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= wr_line.valid;
      end
   end

   // Tag and data arrays carry no reset; a cleared valid bit masks them.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_line.tag;
         data_q[wr_idx] <= wr_line.data;
      end
   end

   always_comb begin
      rd_line       = '0;
      rd_line.valid = valid_q[rd_idx];
      rd_line.tag   = tag_q[rd_idx];
      rd_line.data  = data_q[rd_idx];
   end

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped, blocking instruction cache with a single-outstanding miss-fill FSM.
//   clock, reset          : clock and asynchronous active-low reset
//   proc2Icache_en/addr   : fetch request valid and byte address
//   Icache2proc_data/valid: 64-bit block for the fetch address, valid on hit or fill forward
//   Icache2ctrl_command/addr : load request to the arbiter (BUS_NONE or BUS_LOAD)
//   ctrl2Icache_response  : nonzero = load accepted, value is its transaction tag
//   ctrl2Icache_data/tag  : returning block and its tag (tag 0 = nothing returning)
module icache_fill
   import icache_fill_pkg::*;
#(
   parameter int unsigned NUM_LINES   = ICACHE_LINES,
   parameter int unsigned BLOCK_BYTES = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            proc2Icache_en,
   input  logic [XLEN-1:0] proc2Icache_addr,
   output logic [63:0]     Icache2proc_data,
   output logic            Icache2proc_valid,
   output BUS_COMMAND      Icache2ctrl_command,
   output logic [XLEN-1:0] Icache2ctrl_addr,
   input  logic [3:0]      ctrl2Icache_response,
   input  logic [63:0]     ctrl2Icache_data,
   input  logic [3:0]      ctrl2Icache_tag
);

   localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
   localparam int unsigned TAG_BITS = XLEN - 3 - IDX_BITS;

   if (BLOCK_BYTES != 8) begin : g_bad_block
      $error("icache_fill: BLOCK_BYTES must equal the 64-bit bus width");
   end
   if ((NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_bad_lines
      $error("icache_fill: NUM_LINES must be a power of two");
   end

   ICACHE_STATE         state_q, state_d;
   logic [3:0]          pending_tag_q, pending_tag_d;
   logic [IDX_BITS-1:0] pending_idx_q, pending_idx_d;
   logic [TAG_BITS-1:0] pending_linetag_q, pending_linetag_d;

   logic [IDX_BITS-1:0] cur_idx;
   logic [TAG_BITS-1:0] cur_tag;
   logic [2:0]          unused_offset;
   ICACHE_LINE          rd_line;
   ICACHE_LINE          wr_line;
   logic                hit;
   logic                fill;
   logic                fwd;
   logic                miss_req;

   assign cur_idx       = proc2Icache_addr[3 +: IDX_BITS];
   assign cur_tag       = proc2Icache_addr[XLEN-1 : 3+IDX_BITS];
   assign unused_offset = proc2Icache_addr[2:0];

   assign hit = proc2Icache_en && rd_line.valid && (rd_line.tag == ICACHE_TAG_MAX'(cur_tag));

   // Returning data belongs to us only when its tag matches the one the arbiter handed out.
   assign fill = (state_q == WAIT) && (ctrl2Icache_tag != 4'h0) &&
                 (ctrl2Icache_tag == pending_tag_q);

   // Fetch already sitting on the block being filled gets it in the same cycle.
   assign fwd = fill && proc2Icache_en && (cur_idx == pending_idx_q) &&
                (cur_tag == pending_linetag_q);

   assign miss_req = (state_q == IDLE) && proc2Icache_en && !hit;

   always_comb begin
      wr_line       = '0;
      wr_line.valid = 1'b1;
      wr_line.tag   = ICACHE_TAG_MAX'(pending_linetag_q);
      wr_line.data  = ctrl2Icache_data;
   end

   icache_mem #(
      .NUM_LINES (NUM_LINES)
   ) u_mem (
      .clock   (clock),
      .reset   (reset),
      .rd_idx  (cur_idx),
      .rd_line (rd_line),
      .wr_en   (fill),
      .wr_idx  (pending_idx_q),
      .wr_line (wr_line)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         pending_tag_q     <= 4'h0;
         pending_idx_q     <= '0;
         pending_linetag_q <= '0;
      end else begin
         state_q           <= state_d;
         pending_tag_q     <= pending_tag_d;
         pending_idx_q     <= pending_idx_d;
         pending_linetag_q <= pending_linetag_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d           = state_q;
      pending_tag_d     = pending_tag_q;
      pending_idx_d     = pending_idx_q;
      pending_linetag_d = pending_linetag_q;
      unique case (state_q)
         IDLE: begin
            // A zero response means the request was not taken; retry next cycle.
            if (miss_req && (ctrl2Icache_response != 4'h0)) begin
               state_d           = WAIT;
               pending_tag_d     = ctrl2Icache_response;
               pending_idx_d     = cur_idx;
               pending_linetag_d = cur_tag;
            end
         end
         WAIT: begin
            if (fill) begin
               state_d       = IDLE;
               pending_tag_d = 4'h0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic; reset forces the quiet values even though these paths are combinational.
   always_comb begin
      Icache2ctrl_command = BUS_NONE;
      Icache2ctrl_addr    = '0;
      Icache2proc_valid   = 1'b0;
      Icache2proc_data    = 64'h0;
      if (reset) begin
         if (miss_req) begin
            Icache2ctrl_command = BUS_LOAD;
            Icache2ctrl_addr    = block_addr(proc2Icache_addr);
         end
         if (fwd) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = ctrl2Icache_data;
         end else if (hit) begin
            Icache2proc_valid = 1'b1;
            Icache2proc_data  = rd_line.data;
         end
      end
   end

endmodule

// File: tb/tb_icache_fill.sv
module tb_icache_fill;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_LOAD = 2'd1;

   localparam logic [63:0] D_COLD = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] D_A    = 64'h01234567_89ABCDEF;
   localparam logic [63:0] D_STR  = 64'hBAD0BAD0_55555555;
   localparam logic [63:0] D_C    = 64'hC2C2C2C2_0000C2C2;
   localparam logic [63:0] D_RED  = 64'hD1D1D1D1_12345678;
   localparam logic [63:0] D_E    = 64'hE0E0E0E0_0F0F0F0F;
   localparam logic [63:0] D_F    = 64'hF1F1F1F1_F0F0F0F0;
   localparam logic [63:0] D_RST  = 64'h99999999_99999999;

   logic        clock;
   logic        reset;
   logic        en;
   logic [31:0] addr;
   logic [63:0] pdata;
   logic        pvalid;
   logic [1:0]  ccmd;
   logic [31:0] caddr;
   logic [3:0]  resp;
   logic [63:0] cdata;
   logic [3:0]  ctag;

   icache_fill dut (
      .clock                (clock),
      .reset                (reset),
      .proc2Icache_en       (en),
      .proc2Icache_addr     (addr),
      .Icache2proc_data     (pdata),
      .Icache2proc_valid    (pvalid),
      .Icache2ctrl_command  (ccmd),
      .Icache2ctrl_addr     (caddr),
      .ctrl2Icache_response (resp),
      .ctrl2Icache_data     (cdata),
      .ctrl2Icache_tag      (ctag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [1:0]  cmd;
      logic [31:0] caddr;
      logic        valid;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: one expected item per cycle, checked mid-cycle.
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if (ccmd !== e.cmd) begin
            miscompares++;
            $display("FAIL %s command: got %0d want %0d", e.name, ccmd, e.cmd);
         end
         if (caddr !== e.caddr) begin
            miscompares++;
            $display("FAIL %s ctrl_addr: got %h want %h", e.name, caddr, e.caddr);
         end
         if (pvalid !== e.valid) begin
            miscompares++;
            $display("FAIL %s proc_valid: got %b want %b", e.name, pvalid, e.valid);
         end
         if (pdata !== e.data) begin
            miscompares++;
            $display("FAIL %s proc_data: got %h want %h", e.name, pdata, e.data);
         end
      end
   end

   task automatic step(input string name, input logic rst, input logic e_n,
                       input logic [31:0] a, input logic [3:0] r, input logic [3:0] t,
                       input logic [63:0] d, input logic [1:0] x_cmd,
                       input logic [31:0] x_addr, input logic x_valid,
                       input logic [63:0] x_data);
      exp_t e;
      reset = rst;
      en    = e_n;
      addr  = a;
      resp  = r;
      ctag  = t;
      cdata = d;
      e.name  = name;
      e.cmd   = x_cmd;
      e.caddr = x_addr;
      e.valid = x_valid;
      e.data  = x_data;
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      en    = 1'b1;
      addr  = 32'h104;
      resp  = 4'h0;
      ctag  = 4'h0;
      cdata = 64'h0;
      @(posedge clock);
      #1;

      // Reset held
      step("rst0", 0, 1, 32'h104, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("rst1", 0, 1, 32'h104, 3, 3, D_COLD, CMD_NONE, 0, 0, 0);

      // Cold miss
      step("cold_req",  1, 1, 32'h104, 3, 0, 0, CMD_LOAD, 32'h100, 0, 0);
      step("cold_w2",   1, 1, 32'h104, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("cold_w3",   1, 1, 32'h104, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("cold_w4",   1, 1, 32'h104, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("cold_fwd",  1, 1, 32'h104, 0, 3, D_COLD, CMD_NONE, 0, 1, D_COLD);
      step("cold_hit",  1, 1, 32'h100, 0, 0, 0, CMD_NONE, 0, 1, D_COLD);
      step("en_low",    1, 0, 32'h100, 0, 0, 0, CMD_NONE, 0, 0, 0);

      // Arbiter denial
      for (int i = 0; i < 4; i++)
         step("deny", 1, 1, 32'h208, 0, 0, 0, CMD_LOAD, 32'h208, 0, 0);
      step("deny_acc",  1, 1, 32'h208, 7, 0, 0, CMD_LOAD, 32'h208, 0, 0);
      step("deny_wait", 1, 1, 32'h208, 0, 3, D_STR, CMD_NONE, 0, 0, 0);
      step("deny_fwd",  1, 1, 32'h208, 0, 7, D_A, CMD_NONE, 0, 1, D_A);
      step("deny_hit",  1, 1, 32'h20C, 0, 0, 0, CMD_NONE, 0, 1, D_A);

      // Stray tag
      step("stray_req", 1, 1, 32'h010, 2, 0, 0, CMD_LOAD, 32'h010, 0, 0);
      step("stray_5",   1, 1, 32'h010, 0, 5, D_STR, CMD_NONE, 0, 0, 0);
      step("stray_nowr",1, 1, 32'h010, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("stray_fill",1, 1, 32'h010, 0, 2, D_C, CMD_NONE, 0, 1, D_C);
      step("stray_hit", 1, 1, 32'h014, 0, 0, 0, CMD_NONE, 0, 1, D_C);

      // Redirect during WAIT
      step("redir_req", 1, 1, 32'h200, 1, 0, 0, CMD_LOAD, 32'h200, 0, 0);
      step("redir_w1",  1, 1, 32'h400, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("redir_w2",  1, 1, 32'h400, 2, 0, 0, CMD_NONE, 0, 0, 0);
      step("redir_hit", 1, 1, 32'h208, 0, 0, 0, CMD_NONE, 0, 1, D_A);
      step("redir_fill",1, 1, 32'h400, 0, 1, D_RED, CMD_NONE, 0, 0, 0);
      step("redir_load",1, 1, 32'h400, 0, 0, 0, CMD_LOAD, 32'h400, 0, 0);
      step("redir_line",1, 1, 32'h200, 0, 0, 0, CMD_NONE, 0, 1, D_RED);

      // Conflict eviction on index 0
      step("conf_req0", 1, 1, 32'h000, 6, 0, 0, CMD_LOAD, 32'h000, 0, 0);
      step("conf_fwd0", 1, 1, 32'h000, 0, 6, D_E, CMD_NONE, 0, 1, D_E);
      step("conf_hit0", 1, 1, 32'h004, 0, 0, 0, CMD_NONE, 0, 1, D_E);
      step("conf_req1", 1, 1, 32'h100, 8, 0, 0, CMD_LOAD, 32'h100, 0, 0);
      step("conf_fwd1", 1, 1, 32'h100, 0, 8, D_F, CMD_NONE, 0, 1, D_F);
      step("conf_miss", 1, 1, 32'h000, 0, 0, 0, CMD_LOAD, 32'h000, 0, 0);

      // Reset mid-miss
      step("rm_req",    1, 1, 32'h018, 4, 0, 0, CMD_LOAD, 32'h018, 0, 0);
      step("rm_wait",   1, 1, 32'h018, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("rm_held",   0, 1, 32'h018, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("rm_held2",  0, 1, 32'h208, 0, 0, 0, CMD_NONE, 0, 0, 0);
      step("rm_late4",  1, 1, 32'h018, 0, 4, D_RST, CMD_LOAD, 32'h018, 0, 0);
      step("rm_nowr",   1, 1, 32'h018, 0, 0, 0, CMD_LOAD, 32'h018, 0, 0);
      step("rm_cleared",1, 1, 32'h208, 0, 0, 0, CMD_LOAD, 32'h208, 0, 0);

      en = 1'b0;
      @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Direct-mapped, blocking instruction cache with miss-fill state machine.
- Upstream neighbour of the cache arbiter: it feeds the arbiter's Icache request channel (command/addr) and consumes its Icache response channel (response/data/tag).
- Serves 64-bit fetch blocks to the fetch stage combinationally on a hit.
- Allows one outstanding memory load at a time.

Parameters:
- NUM_LINES, 32, number of cache lines; power of two.
- BLOCK_BYTES, 8, bytes per line; fixed to the 64-bit memory bus width.
- IDX_BITS, $clog2(NUM_LINES), index width; derived, not overridable.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2Icache_en  in  1  fetch request valid this cycle.
- proc2Icache_addr  in  XLEN  fetch byte address.
- Icache2proc_data  out  64  block at {addr[XLEN-1:3],3'b0}.
- Icache2proc_valid  out  1  Icache2proc_data is valid for the current address.
- Icache2ctrl_command  out  2  BUS_NONE or BUS_LOAD; never BUS_STORE.
- Icache2ctrl_addr  out  XLEN  8-byte-aligned load address.
- ctrl2Icache_response  in  4  nonzero means the load was accepted, and the value is its transaction tag.
- ctrl2Icache_data  in  64  returned block.
- ctrl2Icache_tag  in  4  tag of the returning data; 0 means no data this cycle.

Behaviour:
- Address split:
  - offset = addr[2:0]
  - index = addr[3 +: IDX_BITS]
  - line tag = addr[XLEN-1 : 3+IDX_BITS]
- Per-line storage: valid bit, line tag, and 64-bit data.
- Hit, combinational: proc2Icache_en && valid[index] && tag[index]==line tag.
  - Icache2proc_data = data[index] when hit; otherwise 0.
- FSM states: IDLE and WAIT. Registers are pending_tag[3:0], pending_index, and pending_linetag.
- IDLE state:
  - If proc2Icache_en && !hit: drive BUS_LOAD and the aligned current address.
  - If ctrl2Icache_response != 0 in that cycle:
    - pending_tag <= response
    - latch index and line tag from the current address
    - go to WAIT
  - If the response is 0 (arbiter granted Dcache, or memory busy): stay in IDLE and retry next cycle using whatever address is then presented.
  - Otherwise drive BUS_NONE and address 0.
- WAIT state:
  - Drive BUS_NONE and address 0. No new request is issued, even when the fetch address changes and misses.
  - When ctrl2Icache_tag != 0 && ctrl2Icache_tag == pending_tag:
    - write data, line tag and valid=1 to pending_index
    - pending_tag <= 0
    - go to IDLE
  - Non-matching tags are ignored.
- Fill forwarding: in the fill cycle, if proc2Icache_en and the current index and line tag equal the pending ones:
  - Icache2proc_valid=1 and Icache2proc_data=ctrl2Icache_data in that same cycle.
- Hits during WAIT are still served normally.
- Miss latency: at least 1 cycle of request, then the memory latency, then 0 cycles to forward.
- A fill overwrites the line unconditionally; no replacement policy is needed.
- Reset (asynchronous assert) clears:
  - all valid bits
  - FSM to IDLE
  - pending_tag=0, so in-flight data returning after reset never matches, because tag 0 is reserved
- Output values during reset:
  - Icache2ctrl_command=BUS_NONE
  - Icache2ctrl_addr=0
  - Icache2proc_valid=0
  - Icache2proc_data=0
- Data arrays need no reset.
- Outputs are combinational from state and inputs; no output registers.

Decomposition:
- sys_defs.svh:
  - the bus command enum (BUS_NONE/BUS_LOAD/BUS_STORE), already shared
  - new constants ICACHE_LINES and ICACHE_IDX_BITS
  - typedef ICACHE_LINE {valid, line tag, 64-bit data}
  - typedef ICACHE_STATE {IDLE, WAIT}
- One sub-module, icache_mem: the line array with one asynchronous read port and one synchronous write port, plus valid-bit clear on reset.
- icache_fill holds the FSM and the hit/forward logic.

Test Plan:
- Cold miss:
  - Stimulus: after reset, en=1, addr=0x0000_0104, response=3 in cycle 1, tag=3 with data=0xDEADBEEF_CAFEF00D in cycle 5.
  - Required: command=BUS_LOAD, addr=0x100 in cycle 1; valid=1 with forwarded data in cycle 5.
  - Then addr=0x100 hits in cycle 6.
- Arbiter denial:
  - Stimulus: response=0 for 4 cycles, then response=7.
  - Required: BUS_LOAD held all 5 cycles; WAIT entered only after response=7; pending_tag=7.
- Stray tag:
  - Stimulus: in WAIT with pending_tag=2, tags 5 then 2 arrive.
  - Required: tag 5 ignored with no line write; tag 2 fills the line.
- Redirect during WAIT:
  - Stimulus: miss on 0x200 pending, fetch address changes to 0x400, a miss.
  - Required: no second BUS_LOAD until the 0x200 fill completes; the 0x200 line becomes valid; BUS_LOAD 0x400 issues the next cycle.
- Conflict eviction:
  - Stimulus: fill 0x000, then 0x100; index 0 is shared when NUM_LINES=32.
  - Required: re-fetching 0x000 misses and issues a new BUS_LOAD.
- Reset mid-miss:
  - Stimulus: assert reset in WAIT with pending_tag=4; deassert; tag=4 then arrives.
  - Required: no line written, valid=0, command=BUS_NONE while reset is held.
